// File: rtl/mem_bus_responder.sv
// mem_bus_responder
//   Single-port memory slave on a beat-oriented request/response bus.
//   A request starts with an address beat whose tag MSB selects write (1)
//   or read (0).  Writes take 8 further data beats that fill one 64-byte
//   line and complete with a single zero-data response.  Reads return the
//   8 words of the addressed line after READ_LATENCY cycles, one beat per
//   bus_respack.  Memory contents survive reset.
//
//   Optional feature macro: MEM_RESPONDER_CWF_EN
//     defined   -> read beats start at the addressed word and wrap 7->0
//     undefined -> read beats are always words 0..7 of the line
//
// Ports
//   clk          in   clock, all state on rising edge
//   reset        in   asynchronous active-low reset
//   bus_reqcyc   in   request beat valid
//   bus_req      in   address beat, then write data beats
//   bus_reqtag   in   request tag, sampled with the address beat
//   bus_reqack   out  one-cycle accept pulse per request beat
//   bus_respcyc  out  response beat valid
//   bus_resp     out  read data, or 0 for write completion
//   bus_resptag  out  echoed request tag
//   bus_respack  in   requester consumes the current response beat

module mem_bus_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 512,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int AW    = $clog2(MEM_WORDS);
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WDATA = 3'd1;
  localparam logic [2:0] RWAIT = 3'd2;
  localparam logic [2:0] RDATA = 3'd3;
  localparam logic [2:0] WRESP = 3'd4;

  logic [2:0]               state;
  logic [2:0]               beat;
  logic [LAT_W-1:0]         lat_cnt;

  // Line index (word address >> 3), addressed word and tag of the
  // transaction in flight; pure data, never reset.
  logic [AW-4:0]            line_idx;
  logic [2:0]               crit_word;
  logic [BUS_TAG_WIDTH-1:0] tag;

  logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic          accept;
  logic          is_write;
  logic          wr_en;
  logic [2:0]    rd_word;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  // Address bits outside the aliased word range are intentionally ignored.
  logic unused_req_bits;
  assign unused_req_bits = ^{bus_req[BUS_DATA_WIDTH-1:AW+3], bus_req[2:0]};

  // A beat is only sampled when the previous ack pulse has ended, so each
  // held beat is taken exactly once.
  assign accept   = bus_reqcyc && !bus_reqack && ((state == IDLE) || (state == WDATA));
  assign is_write = bus_reqtag[BUS_TAG_WIDTH-1];
  assign wr_en    = accept && (state == WDATA);

`ifdef MEM_RESPONDER_CWF_EN
  assign rd_word = crit_word + beat;
`else
  assign rd_word = beat;
`endif

  assign wr_addr = {line_idx, beat};
  assign rd_addr = {line_idx, rd_word};

  // Control state: asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      beat       <= 3'd0;
      lat_cnt    <= '0;
      bus_reqack <= 1'b0;
    end else begin
      bus_reqack <= accept;
      case (state)
        IDLE: begin
          if (accept) begin
            beat    <= 3'd0;
            lat_cnt <= '0;
            state   <= is_write ? WDATA : RWAIT;
          end
        end
        WDATA: begin
          if (accept) begin
            beat <= beat + 3'd1;
            if (beat == 3'd7) state <= WRESP;
          end
        end
        RWAIT: begin
          // The ack cycle is the first of the READ_LATENCY wait cycles.
          if (lat_cnt == LAT_W'(READ_LATENCY - 1)) begin
            lat_cnt <= '0;
            state   <= RDATA;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        RDATA: begin
          if (bus_respack) begin
            beat <= beat + 3'd1;
            if (beat == 3'd7) state <= IDLE;
          end
        end
        WRESP: begin
          if (bus_respack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Transaction attributes latched on the address beat.
  always_ff @(posedge clk) begin
    if (accept && (state == IDLE)) begin
      line_idx  <= bus_req[AW+2:6];
      crit_word <= bus_req[5:3];
      tag       <= bus_reqtag;
    end
  end

  // Backing store: each write beat lands in the cycle it is accepted.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= bus_req;
  end

  // Response outputs decode straight from state so reset clears them at once.
  always_comb begin
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    if (state == RDATA) begin
      bus_respcyc = 1'b1;
      bus_resp    = mem[rd_addr];
      bus_resptag = tag;
    end else if (state == WRESP) begin
      bus_respcyc = 1'b1;
      bus_resptag = tag;
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
module tb_mem_bus_responder;

  localparam int DW = 64;
  localparam int TW = 13;
  localparam int MW = 512;
  localparam int RL = 4;
`ifdef MEM_RESPONDER_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bus_reqcyc;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  logic          bus_respack;

  mem_bus_responder #(
    .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .MEM_WORDS(MW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(rst_n),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .bus_respack(bus_respack)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference memory: word-addressed, line = 8 consecutive words.
  logic [63:0] ref_mem [MW];

  // Request held during a read to exercise the busy-ignore rule.
  logic          nxt_v = 1'b0;
  logic [DW-1:0] nxt_a = '0;
  logic [TW-1:0] nxt_t = '0;

  function automatic int word_addr(input logic [63:0] addr, input int k);
    longint unsigned first_word;
    first_word = (longint'(addr) / 64) * 8;
    return int'((first_word + longint'(k)) % MW);
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_respcyc"}, 64'(bus_respcyc), 64'd0);
    check({name, "_resp"}, bus_resp, 64'd0);
    check({name, "_resptag"}, 64'(bus_resptag), 64'd0);
  endtask

  task automatic wait_ack(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_reqack) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_ack_seen"}, 64'(ok), 64'd1);
  endtask

  // Full write transaction; abort_after>0 returns right after that many
  // data beats are acknowledged, leaving the next beat on the bus.
  task automatic write_line(input logic [63:0] addr, input logic [TW-1:0] tag,
                            input logic [63:0] d [8], input int stall_n,
                            input int abort_after);
    bit ok;
    int acks;
    acks = 0;
    bus_reqcyc = 1'b1;
    bus_req    = addr;
    bus_reqtag = tag;
    wait_ack("wr_addr", ok);
    if (ok) acks++;
    for (int k = 0; k < 8; k++) begin
      bus_req = d[k];
      @(negedge clk);
      check("wr_ack_pulse_width", 64'(bus_reqack), 64'd0);
      wait_ack("wr_data", ok);
      if (ok) begin
        acks++;
        ref_mem[word_addr(addr, k)] = d[k];
      end
      if (abort_after == k + 1) return;
    end
    bus_reqcyc = 1'b0;
    bus_req    = '0;
    bus_reqtag = '0;
    check("wr_ack_count", 64'(acks), 64'd9);
    for (int s = 0; s <= stall_n; s++) begin
      bus_respack = (s == stall_n);
      check("wr_resp_cyc", 64'(bus_respcyc), 64'd1);
      check("wr_resp_data", bus_resp, 64'd0);
      check("wr_resp_tag", 64'(bus_resptag), 64'(tag));
      @(negedge clk);
    end
    bus_respack = 1'b0;
    check_idle_outputs("wr_done");
  endtask

  // Full read transaction; abort_beat>=0 returns when that beat is first shown.
  task automatic read_line(input logic [63:0] addr, input logic [TW-1:0] tag,
                           input int stall_beat, input int stall_n,
                           input int abort_beat);
    bit ok;
    bit seen;
    int lat;
    int n;
    int w;
    bus_reqcyc = 1'b1;
    bus_req    = addr;
    bus_reqtag = tag;
    wait_ack("rd_addr", ok);
    bus_reqcyc = nxt_v;
    bus_req    = nxt_a;
    bus_reqtag = nxt_t;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < RL + 16; i++) begin
      @(negedge clk);
      lat++;
      bus_respack = 1'($urandom_range(0, 1));
      if (bus_respcyc) begin
        seen = 1'b1;
        break;
      end
      check("rd_wait_noack", 64'(bus_reqack), 64'd0);
    end
    check("rd_first_seen", 64'(seen), 64'd1);
    if (!seen) begin
      bus_respack = 1'b0;
      return;
    end
    check("rd_latency", 64'(lat), 64'(RL));
    for (int b = 0; b < 8; b++) begin
      n = (b == stall_beat) ? stall_n : 0;
      w = CWF ? ((int'(addr[5:3]) + b) % 8) : b;
      for (int s = 0; s <= n; s++) begin
        bus_respack = 1'b0;
        check("rd_beat_cyc", 64'(bus_respcyc), 64'd1);
        check("rd_beat_data", bus_resp, ref_mem[word_addr(addr, w)]);
        check("rd_beat_tag", 64'(bus_resptag), 64'(tag));
        check("rd_busy_noack", 64'(bus_reqack), 64'd0);
        if (b == abort_beat) return;
        bus_respack = (s == n);
        @(negedge clk);
      end
    end
    bus_respack = 1'b0;
    check_idle_outputs("rd_done");
    check("rd_done_noack", 64'(bus_reqack), 64'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_reqack", 64'(bus_reqack), 64'd0);
    check_idle_outputs("rst");
    bus_reqcyc  = 1'b0;
    bus_respack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d [8];
    logic [63:0] addr;
    logic [TW-1:0] tag;

    rst_n       = 1'b0;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_reqack", 64'(bus_reqack), 64'd0);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: write line at 0x1000, then read it back
    for (int k = 0; k < 8; k++) d[k] = 64'h11 * (k + 1);
    write_line(64'h1000, 13'h1005, d, 2, -1);
    read_line(64'h1000, 13'h0005, -1, 0, -1);

    // Read from the middle of the line (order depends on CWF)
    read_line(64'h1028, 13'h0007, -1, 0, -1);

    // Held response beat
    read_line(64'h1010, 13'h0002, 2, 3, -1);

    // Requester keeps a new request up during a read
    nxt_v = 1'b1; nxt_a = 64'h1018; nxt_t = 13'h0009;
    read_line(64'h1000, 13'h0003, -1, 0, -1);
    nxt_v = 1'b0;
    read_line(64'h1018, 13'h0009, 5, 1, -1);

    // Reset in the middle of a write
    for (int k = 0; k < 8; k++) d[k] = 64'hA000 + 64'(k);
    write_line(64'h0040, 13'h1001, d, 0, -1);
    for (int k = 0; k < 8; k++) d[k] = 64'hB000 + 64'(k);
    write_line(64'h0040, 13'h1002, d, 0, 4);
    pulse_reset();
    read_line(64'h0040, 13'h0004, -1, 0, -1);
    for (int k = 0; k < 8; k++) d[k] = 64'hC000 + 64'(k);
    write_line(64'h0040, 13'h1006, d, 1, -1);
    read_line(64'h0058, 13'h0006, -1, 0, -1);

    // Reset in the middle of a read
    read_line(64'h0000, 13'h000A, -1, 0, 3);
    pulse_reset();
    read_line(64'h0000, 13'h000B, -1, 0, -1);

    // Fill remaining lines used by the random phase
    for (int li = 2; li < 6; li++) begin
      for (int k = 0; k < 8; k++) d[k] = {$urandom, $urandom};
      write_line(64'(li * 64), {1'b1, 12'($urandom)}, d, 0, -1);
    end

    // Randomized mix over aliased addresses
    for (int t = 0; t < 24; t++) begin
      addr = (64'($urandom_range(0, 255)) << 12) + 64'($urandom_range(0, 5) * 64)
             + 64'($urandom_range(0, 63));
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < 8; k++) d[k] = {$urandom, $urandom};
        tag = {1'b1, 12'($urandom)};
        write_line(addr, tag, d, $urandom_range(0, 3), -1);
      end else begin
        tag = {1'b0, 12'($urandom)};
        read_line(addr, tag, $urandom_range(0, 7), $urandom_range(0, 2), -1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, data/address beat width.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, tag width; MSB = write flag (1 write, 0 read), remaining bits = transaction id.
REQ-003 SHALL have parameter MEM_WORDS, default 512, backing-store depth in 64-bit words (power of two).
REQ-004 SHALL have parameter READ_LATENCY, default 4, cycles from read-address accept to first read beat (minimum 1).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port bus_reqcyc  input  1  requester beat valid.
REQ-008 SHALL have port bus_req  input  BUS_DATA_WIDTH  address beat, then write-data beats.
REQ-009 SHALL have port bus_reqtag  input  BUS_TAG_WIDTH  request tag, sampled on the address beat.
REQ-010 SHALL have port bus_reqack  output  1  one-cycle accept pulse per request beat.
REQ-011 SHALL have port bus_respcyc  output  1  response beat valid.
REQ-012 SHALL have port bus_resp  output  BUS_DATA_WIDTH  read data, or 0 for write completion.
REQ-013 SHALL have port bus_resptag  output  BUS_TAG_WIDTH  echo of the accepted request tag.
REQ-014 SHALL have port bus_respack  input  1  requester consumes current response beat.

Function
REQ-015 SHALL implement states IDLE, WDATA, RWAIT, RDATA, WRESP.
REQ-016 SHALL accept a beat when bus_reqcyc=1 and bus_reqack=0 in IDLE or WDATA, asserting bus_reqack for exactly the following cycle; no beat is sampled during the ack cycle.
REQ-017 SHALL ignore bus_reqcyc (no ack) in RWAIT, RDATA, WRESP; the requester holds its beat.
REQ-018 SHALL, on an address beat, latch line base = bus_req with bits [5:0] cleared, word index = bus_req[5:3], and tag; line word address = (bus_req>>3) mod MEM_WORDS.
REQ-019 SHALL, for a write tag, go to WDATA and write each of 8 accepted data beats to consecutive words of the line (beat k -> word k) in the accept cycle, then enter WRESP.
REQ-020 SHALL, in WRESP, hold bus_respcyc=1, bus_resp=0, bus_resptag=tag until a cycle with bus_respack=1, then return to IDLE.
REQ-021 SHALL, for a read tag, go to RWAIT, count READ_LATENCY cycles, then enter RDATA.
REQ-022 SHALL, in RDATA, drive 8 beats with bus_respcyc=1 and bus_resptag=tag; each beat is held stable until bus_respack=1, advancing to the next beat the cycle after; after beat 8 is acked, return to IDLE.
REQ-023 SHALL drive bus_resp=0 and bus_resptag=0 whenever bus_respcyc=0.
REQ-024 SHALL wrap beat counter 7->0 within the line; addresses beyond MEM_WORDS alias modulo MEM_WORDS.
REQ-025 SHALL handle bus_respack asserted while bus_respcyc=0 as a no-op.

Reset
REQ-026 SHALL, on reset low (any time, including mid-transaction), immediately force IDLE and bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0, counters 0.
REQ-027 SHALL not clear memory contents on reset; write beats completed before reset remain written.
REQ-028 SHALL resume accepting on the first rising edge after reset returns high.

Configuration
REQ-029 SHALL, with macro MEM_RESPONDER_CWF_EN defined, return read beats critical-word-first: first beat = latched word index, then ascending, wrapping 7->0.
REQ-030 SHALL, without MEM_RESPONDER_CWF_EN, always return read beats in order word 0..7 regardless of address bits [5:3].

Verification
REQ-031 SHALL pass: write addr 0x1000 tag 0x1005, data 0x11..0x88 -> 9 reqack pulses, then respcyc with resp=0, resptag=0x1005 until respack.
REQ-032 SHALL pass: read addr 0x1000 tag 0x0005 after REQ-031 -> first respcyc exactly READ_LATENCY cycles after ack cycle, beats 0x11..0x88, resptag=0x0005.
REQ-033 SHALL pass: read addr 0x1028 with MEM_RESPONDER_CWF_EN -> beats 0x66,0x77,0x88,0x11..0x55; without macro -> 0x11..0x88.
REQ-034 SHALL pass: respack withheld 3 cycles on beat 2 -> bus_resp stable at beat 2 value, no beat lost or duplicated.
REQ-035 SHALL pass: reqcyc held high during RDATA -> no reqack until IDLE, then accepted.
REQ-036 SHALL pass: reset low after 4th write data beat -> outputs 0 same cycle, words 0-3 updated, words 4-7 unchanged, next request serviced normally.
